// File: rtl/alu_exec_unit.sv
// Registered ALU execution unit: single-cycle add/sub/slt and a fixed-latency
// iterative shift-add multiply, with a Start/Busy/Done handshake.
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Start,
   input  logic [2:0]       ALUControl,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             Illegal
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b101;

   typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

   typedef struct packed {
      logic             wr;
      logic             ill;
      logic [WIDTH-1:0] res;
   } wb_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, mcand, mplr;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc_sum;
   logic             slt_lt;
   logic             load_mul;
   wb_t              wb;

   assign Busy    = (state == MUL);
   assign acc_sum = acc + (mplr[0] ? mcand : '0);
   assign slt_lt  = $signed(SrcA) < $signed(SrcB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state plus the write-back bundle for the edge that ends this cycle.
   always_comb begin
      state_nxt = state;
      load_mul  = 1'b0;
      wb        = '0;
      case (state)
         IDLE: begin
            if (Start) begin
               case (ALUControl)
                  OP_ADD: begin
                     wb.wr  = 1'b1;
                     wb.res = SrcA + SrcB;
                  end
                  OP_SUB: begin
                     wb.wr  = 1'b1;
                     wb.res = SrcA - SrcB;
                  end
                  OP_SLT: begin
                     wb.wr  = 1'b1;
                     wb.res = {{(WIDTH-1){1'b0}}, slt_lt};
                  end
                  OP_MUL: begin
                     load_mul  = 1'b1;
                     state_nxt = MUL;
                  end
                  default: begin
                     wb.wr  = 1'b1;
                     wb.ill = 1'b1;
                  end
               endcase
            end
         end
         MUL: begin
            if (cnt == LAST) begin
               wb.wr     = 1'b1;
               wb.res    = acc_sum;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Shift-add core: one multiplier bit per cycle, always WIDTH iterations.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         mcand <= '0;
         mplr  <= '0;
         cnt   <= '0;
      end else if (load_mul) begin
         acc   <= '0;
         mcand <= SrcA;
         mplr  <= SrcB;
         cnt   <= '0;
      end else if (state == MUL) begin
         acc   <= acc_sum;
         mcand <= mcand << 1;
         mplr  <= mplr >> 1;
         cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Done      <= 1'b0;
         ALUResult <= '0;
         Zero      <= 1'b0;
         Illegal   <= 1'b0;
      end else begin
         Done <= wb.wr;
         if (wb.wr) begin
            ALUResult <= wb.res;
            Zero      <= (wb.res == '0);
            Illegal   <= wb.ill;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, outputs sampled 1ns after rising edges.
module tb_alu_exec_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         Start;
   logic [2:0]   ALUControl;
   logic [W-1:0] SrcA, SrcB;
   logic         Busy, Done, Zero, Illegal;
   logic [W-1:0] ALUResult;

   int total = 0;
   int bad   = 0;
   logic seen_done;

   alu_exec_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .Start(Start), .ALUControl(ALUControl),
      .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done),
      .ALUResult(ALUResult), .Zero(Zero), .Illegal(Illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives a request during cycle 0 and returns 1ns into cycle 1; Start stays high.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      Start      = 1'b1;
      ALUControl = op;
      SrcA       = a;
      SrcB       = b;
      tick();
   endtask

   task automatic chk_zero_outs(input string tag);
      chk({tag, ".busy"}, W'(Busy), 0);
      chk({tag, ".done"}, W'(Done), 0);
      chk({tag, ".res"},  ALUResult, 0);
      chk({tag, ".zero"}, W'(Zero), 0);
      chk({tag, ".ill"},  W'(Illegal), 0);
   endtask

   initial begin
      rst_n = 1'b0; Start = 1'b0; ALUControl = 3'b000; SrcA = '0; SrcB = '0;
      tick(); tick();
      chk_zero_outs("reset");
      rst_n = 1'b1;
      tick();

      // add and add wrap
      issue(3'b010, 32'd5, 32'd7);
      chk("add.done", W'(Done), 1);
      chk("add.res",  ALUResult, 32'd12);
      chk("add.zero", W'(Zero), 0);
      chk("add.busy", W'(Busy), 0);
      issue(3'b010, 32'hFFFF_FFFF, 32'd1);
      chk("addw.done", W'(Done), 1);
      chk("addw.res",  ALUResult, 32'd0);
      chk("addw.zero", W'(Zero), 1);

      // sub then slt back to back
      issue(3'b100, 32'd7, 32'd7);
      chk("sub.done", W'(Done), 1);
      chk("sub.res",  ALUResult, 32'd0);
      chk("sub.zero", W'(Zero), 1);
      issue(3'b110, 32'hFFFF_FFFF, 32'd1);
      chk("slt.done", W'(Done), 1);
      chk("slt.res",  ALUResult, 32'd1);
      chk("slt.zero", W'(Zero), 0);
      Start = 1'b0;
      tick();
      chk("idle.done", W'(Done), 0);
      chk("idle.res",  ALUResult, 32'd1);

      // 6 x 7 with an add attempted in cycle 10 while busy
      issue(3'b101, 32'd6, 32'd7);
      Start = 1'b0;
      for (int c = 1; c <= W; c++) begin
         chk($sformatf("mul.busy%0d", c), W'(Busy), 1);
         chk($sformatf("mul.done%0d", c), W'(Done), 0);
         if (c == 10) begin
            Start = 1'b1; ALUControl = 3'b010; SrcA = 32'd1; SrcB = 32'd1;
         end else begin
            Start = 1'b0;
         end
         tick();
      end
      chk("mul.done", W'(Done), 1);
      chk("mul.busy", W'(Busy), 0);
      chk("mul.res",  ALUResult, 32'd42);
      tick();
      chk("mul.after.done", W'(Done), 0);
      chk("mul.after.res",  ALUResult, 32'd42);

      // FFFFFFFF x 2, then accept an add in the mul Done cycle
      issue(3'b101, 32'hFFFF_FFFF, 32'd2);
      Start = 1'b0;
      for (int c = 1; c <= W; c++) tick();
      chk("mul2.done", W'(Done), 1);
      chk("mul2.res",  ALUResult, 32'hFFFF_FFFE);
      issue(3'b010, 32'd1, 32'd1);
      Start = 1'b0;
      chk("ondone.done", W'(Done), 1);
      chk("ondone.res",  ALUResult, 32'd2);

      // illegal code, then a legal add clears Illegal
      issue(3'b000, 32'd3, 32'd4);
      chk("ill.done", W'(Done), 1);
      chk("ill.flag", W'(Illegal), 1);
      chk("ill.res",  ALUResult, 32'd0);
      chk("ill.zero", W'(Zero), 1);
      issue(3'b010, 32'd2, 32'd3);
      Start = 1'b0;
      chk("illclr.flag", W'(Illegal), 0);
      chk("illclr.res",  ALUResult, 32'd5);

      // reset in cycle 10 of a 9 x 9 multiply
      issue(3'b101, 32'd9, 32'd9);
      Start = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      chk("rstmul.busy", W'(Busy), 1);
      rst_n = 1'b0;
      #1;
      chk_zero_outs("rstmul");
      tick(); tick();
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (Done) seen_done = 1'b1;
      end
      chk("rstmul.nodone", W'(seen_done), 0);
      chk("rstmul.res", ALUResult, 32'd0);
      issue(3'b010, 32'd2, 32'd2);
      Start = 1'b0;
      chk("post.done", W'(Done), 1);
      chk("post.res",  ALUResult, 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
